// File: rtl/i2c_cfg_sequencer_pkg.sv
// Purpose: shared opcodes, entry layout and FSM encoding for the I2C config sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_cfg_sequencer_pkg;

  // Table opcodes carried in the address byte of an entry
  localparam logic [7:0] OP_END   = 8'hFE;
  localparam logic [7:0] OP_DELAY = 8'hFF;

  // One table entry: {addr[15:8], data[7:0]}
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RELEASE,
    ST_DELAY,
    ST_FINISH,
    ST_FAULT
  } state_t;

  // Default bring-up table, entry 0 in the least significant 16 bits:
  // soft reset, wait 5 ms, two config writes, end.
  localparam int DEF_ENTRIES = 16;
  localparam logic [DEF_ENTRIES*16-1:0] DEF_TABLE = {
    {11{16'hFE00}},
    16'hFE00,
    16'h2110,
    16'h2001,
    16'hFF05,
    16'h1A80
  };

endpackage

// File: rtl/i2c_cfg_sequencer_rom.sv
// Purpose: combinational lookup of one 16-bit table entry by index.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; out-of-range indices read as all-zero.
module i2c_cfg_sequencer_rom
  import i2c_cfg_sequencer_pkg::*;
#(
  parameter int                        NUM_ENTRIES = DEF_ENTRIES,
  parameter logic [NUM_ENTRIES*16-1:0] TABLE       = DEF_TABLE,
  localparam int                       IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic [IDX_W-1:0] index,
  output entry_t           entry
);

  // Select the entry whose slot matches the index
  always_comb begin
    entry = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (index == IDX_W'(i)) entry = TABLE[i*16 +: 16];
    end
  end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Purpose: walks a register/value table and drives i2c_master enable/reg_addr/data_in.
// Latency: start -> enable high after 2 edges (+ power-up wait); done -> enable low on the sampling edge.
// Backpressure: holds each write until i2c_done high then low; gives up after the timeout.
module i2c_cfg_sequencer
  import i2c_cfg_sequencer_pkg::*;
#(
  parameter int                        NUM_ENTRIES = DEF_ENTRIES,
  parameter int                        MS_CYCLES   = 32000,
  parameter int                        PWRUP_MS    = 10,
  parameter int                        TIMEOUT_MS  = 5,
  parameter logic [NUM_ENTRIES*16-1:0] TABLE       = DEF_TABLE,
  localparam int                       IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic             clk_32M,
  input  logic             rst_n,
  input  logic             start,
  input  logic             i2c_done,
  output logic             i2c_enable,
  output logic [7:0]       reg_addr,
  output logic [7:0]       data_in,
  output logic             busy,
  output logic             cfg_done,
  output logic             cfg_error,
  output logic [IDX_W-1:0] entry_index
);

  localparam logic [31:0]      MS_LAST  = 32'(MS_CYCLES - 1);
  localparam logic [31:0]      PWR_LAST = 32'(PWRUP_MS - 1);
  localparam logic [31:0]      TO_LAST  = 32'(TIMEOUT_MS * MS_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

  state_t      state_q, state_d;
  entry_t      entry;
  logic [31:0] presc_q, ms_q, to_q;
  logic        idx_adv, tick, at_last, timed, to_hit;

  i2c_cfg_sequencer_rom #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .TABLE       (TABLE)
  ) u_rom (
    .index (entry_index),
    .entry (entry)
  );

  assign tick    = (presc_q == MS_LAST);
  assign at_last = (entry_index == IDX_LAST);
  assign timed   = state_q inside {ST_PWRUP, ST_DELAY, ST_WAIT_DONE, ST_RELEASE};
  assign to_hit  = (to_q == TO_LAST);

  // Next-state decode; idx_adv marks the cycle an entry is retired
  always_comb begin
    state_d = state_q;
    idx_adv = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = (PWRUP_MS == 0) ? ST_FETCH : ST_PWRUP;
      end
      ST_PWRUP: begin
        if (tick && ms_q == PWR_LAST) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (entry.addr == OP_END) begin
          state_d = ST_FINISH;
        end else if (entry.addr == OP_DELAY) begin
          // A zero-length delay retires straight from FETCH
          if (entry.data == 8'd0) begin
            idx_adv = 1'b1;
            state_d = at_last ? ST_FINISH : ST_FETCH;
          end else begin
            state_d = ST_DELAY;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (i2c_done)    state_d = ST_RELEASE;
        else if (to_hit) state_d = ST_FAULT;
      end
      ST_RELEASE: begin
        if (!i2c_done) begin
          idx_adv = 1'b1;
          state_d = at_last ? ST_FINISH : ST_FETCH;
        end else if (to_hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_DELAY: begin
        if (tick && ms_q == ({24'd0, entry.data} - 32'd1)) begin
          idx_adv = 1'b1;
          state_d = at_last ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_FAULT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_32M or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ms prescaler and ms counter: run only in timed states, restart on every state change
  always_ff @(posedge clk_32M or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      ms_q    <= '0;
    end else if (!timed || state_d != state_q) begin
      presc_q <= '0;
      ms_q    <= '0;
    end else if (tick) begin
      presc_q <= '0;
      ms_q    <= ms_q + 32'd1;
    end else begin
      presc_q <= presc_q + 32'd1;
    end
  end

  // Per-entry timeout: zeroed as a write is issued, spans ISSUE through RELEASE
  always_ff @(posedge clk_32M or negedge rst_n) begin
    if (!rst_n)                                                  to_q <= '0;
    else if (state_q == ST_FETCH)                                to_q <= '0;
    else if (state_q inside {ST_ISSUE, ST_WAIT_DONE, ST_RELEASE}) to_q <= to_q + 32'd1;
  end

  // Registered outputs; enable follows the next state so it drops on the done-sampling edge
  always_ff @(posedge clk_32M or negedge rst_n) begin
    if (!rst_n) begin
      i2c_enable  <= 1'b0;
      reg_addr    <= 8'h00;
      data_in     <= 8'h00;
      busy        <= 1'b0;
      cfg_done    <= 1'b0;
      cfg_error   <= 1'b0;
      entry_index <= '0;
    end else begin
      i2c_enable <= (state_d == ST_WAIT_DONE);
      if (state_q == ST_IDLE && start) begin
        busy        <= 1'b1;
        cfg_done    <= 1'b0;
        cfg_error   <= 1'b0;
        entry_index <= '0;
      end else if (idx_adv && !at_last) begin
        entry_index <= entry_index + IDX_W'(1);
      end
      if (state_q == ST_FETCH && state_d == ST_ISSUE) begin
        reg_addr <= entry.addr;
        data_in  <= entry.data;
      end
      if (state_d == ST_FINISH) begin
        cfg_done <= 1'b1;
        busy     <= 1'b0;
      end
      if (state_d == ST_FAULT) begin
        cfg_error <= 1'b1;
        busy      <= 1'b0;
      end
    end
  end

endmodule
